// File: rtl/ibr128_pkg.sv
// Shared types for the IBR128 request arbiter: FSM states, request record
// and mode-of-operation constants.
package ibr128_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_RESP = 3'd3,
    ST_GAP  = 3'd4
  } ibr128_state_t;

  localparam logic [1:0] SOM_ECB = 2'd0;
  localparam logic [1:0] SOM_CBC = 2'd1;
  localparam logic [1:0] SOM_CFB = 2'd2;
  localparam logic [1:0] SOM_OFB = 2'd3;

  typedef struct packed {
    logic         encrypt;
    logic         sa;
    logic         fb;
    logic [1:0]   som;
    logic [127:0] text;
    logic [127:0] iv;
    logic [63:0]  key0;
    logic [63:0]  key1;
  } ibr128_req_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ibr128_rr_arb.sv
// Two-way round-robin arbiter: combinational grant from the current valids,
// last-grant register advanced only when a grant is taken.
module ibr128_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       update,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic last_r;

  // Grant selection; on a tie the requester not granted last wins.
  always_comb begin
    grant     = 2'b00;
    grant_idx = 1'b0;
    case (valid)
      2'b01: begin
        grant     = 2'b01;
        grant_idx = 1'b0;
      end
      2'b10: begin
        grant     = 2'b10;
        grant_idx = 1'b1;
      end
      2'b11: begin
        if (last_r) begin
          grant     = 2'b01;
          grant_idx = 1'b0;
        end else begin
          grant     = 2'b10;
          grant_idx = 1'b1;
        end
      end
      default: begin
        grant     = 2'b00;
        grant_idx = 1'b0;
      end
    endcase
  end

  // Last-grant pointer; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (update) begin
      last_r <= grant_idx;
    end
  end

endmodule

// File: rtl/ibr128_arbiter.sv
// Shares one IBR128 core between two requesters (round-robin, one transaction
// at a time). Define IBR128_ARB_TIMEOUT_EN to add the RUN watchdog and rsp_err.
module ibr128_arbiter
  import ibr128_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                Clk,
  input  logic                RstN,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_encrypt,
  input  logic [1:0]          req_sa,
  input  logic [1:0]          req_fb,
  input  logic [1:0][1:0]     req_som,
  input  logic [1:0][127:0]   req_text,
  input  logic [1:0][127:0]   req_iv,
  input  logic [1:0][63:0]    req_key0,
  input  logic [1:0][63:0]    req_key1,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [127:0]        rsp_text,
  output logic                core_Enable,
  output logic                core_SA,
  output logic                core_Encrypt,
  output logic                core_FB,
  output logic [1:0]          core_SOM,
  output logic [127:0]        core_plainText,
  output logic [127:0]        core_IV,
  output logic [63:0]         core_key0,
  output logic [63:0]         core_key1,
  input  logic [127:0]        core_cipherText,
  input  logic                core_cipherReady
`ifdef IBR128_ARB_TIMEOUT_EN
  ,
  output logic                rsp_err
`endif
);

  ibr128_state_t state_r, next_state_s;
  ibr128_req_t   req_s [2];
  ibr128_req_t   core_req_r;
  logic [1:0]    grant_s;
  logic          grant_idx_s;
  logic          accept_s;
  logic [1:0]    req_ready_s;
  logic          timeout_s;
  logic          owner_r;
  logic          core_enable_r;
  logic [1:0]    rsp_valid_r;
  logic [127:0]  rsp_text_r;
  logic [3:0]    gap_cnt_r;

`ifdef IBR128_ARB_TIMEOUT_EN
  localparam int unsigned RUN_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [RUN_W-1:0] run_cnt_r;
  logic             rsp_err_r;
`else
  // The watchdog limit has no effect in this build.
  logic [31:0] timeout_unused_s;
  assign timeout_unused_s = 32'(TIMEOUT_CYCLES);
`endif

  ibr128_rr_arb u_rr_arb (
    .clk       (Clk),
    .rst_n     (RstN),
    .valid     (req_valid),
    .update    (accept_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign accept_s = (state_r == ST_IDLE) && (|req_valid);

  // Gather each requester's fields into one record.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req_s[i] = '{encrypt: req_encrypt[i], sa: req_sa[i], fb: req_fb[i],
                   som: req_som[i], text: req_text[i], iv: req_iv[i],
                   key0: req_key0[i], key1: req_key1[i]};
    end
  end

  // Next-state decode; the grant pulse exists only in IDLE.
  always_comb begin
    next_state_s = state_r;
    req_ready_s  = 2'b00;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready_s  = grant_s;
          next_state_s = ST_LOAD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: next_state_s = ST_RUN;
      ST_RUN: begin
        if (core_cipherReady) begin
          next_state_s = ST_RESP;
`ifdef IBR128_ARB_TIMEOUT_EN
        end else if (run_cnt_r == RUN_W'(TIMEOUT_CYCLES - 1)) begin
          next_state_s = ST_RESP;
          timeout_s    = 1'b1;
`endif
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_RESP: begin
        if (rsp_ready[owner_r]) begin
          next_state_s = ST_GAP;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == 4'(GAP_CYCLES - 1)) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, latched request, result and counters.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state_r       <= ST_IDLE;
      core_req_r    <= '0;
      owner_r       <= 1'b0;
      core_enable_r <= 1'b0;
      rsp_valid_r   <= 2'b00;
      rsp_text_r    <= 128'd0;
      gap_cnt_r     <= 4'd0;
    end else begin
      state_r       <= next_state_s;
      core_enable_r <= (next_state_s == ST_RUN);
      rsp_valid_r   <= (next_state_s == ST_RESP) ? onehot2(owner_r) : 2'b00;
      gap_cnt_r     <= (state_r == ST_GAP) ? gap_cnt_r + 4'd1 : 4'd0;
      if (accept_s) begin
        core_req_r <= req_s[grant_idx_s];
        owner_r    <= grant_idx_s;
      end
      if ((state_r == ST_RUN) && (next_state_s == ST_RESP)) begin
        rsp_text_r <= timeout_s ? 128'd0 : core_cipherText;
      end
    end
  end

`ifdef IBR128_ARB_TIMEOUT_EN
  // RUN-cycle watchdog; error flag lives for the whole timed-out RESP.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      run_cnt_r <= '0;
      rsp_err_r <= 1'b0;
    end else begin
      run_cnt_r <= (state_r == ST_RUN) ? run_cnt_r + RUN_W'(1) : '0;
      rsp_err_r <= (next_state_s == ST_RESP) &&
                   (timeout_s || ((state_r == ST_RESP) && rsp_err_r));
    end
  end

  assign rsp_err = rsp_err_r;
`endif

  assign req_ready      = req_ready_s;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_text       = rsp_text_r;
  assign core_Enable    = core_enable_r;
  assign core_SA        = core_req_r.sa;
  assign core_Encrypt   = core_req_r.encrypt;
  assign core_FB        = core_req_r.fb;
  assign core_SOM       = core_req_r.som;
  assign core_plainText = core_req_r.text;
  assign core_IV        = core_req_r.iv;
  assign core_key0      = core_req_r.key0;
  assign core_key1      = core_req_r.key1;

endmodule

// File: tb/tb_ibr128_arbiter.sv
// Directed, table-driven bench for ibr128_arbiter with a simple core model
// (result = ~plainText, ready 10 cycles after Enable rises).
module tb_ibr128_arbiter;
  import ibr128_pkg::*;

  localparam int GAP = 2;

  logic              Clk;
  logic              RstN;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_encrypt, req_sa, req_fb;
  logic [1:0][1:0]   req_som;
  logic [1:0][127:0] req_text, req_iv;
  logic [1:0][63:0]  req_key0, req_key1;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [127:0]      rsp_text;
  logic              core_Enable, core_SA, core_Encrypt, core_FB;
  logic [1:0]        core_SOM;
  logic [127:0]      core_plainText, core_IV;
  logic [63:0]       core_key0, core_key1;
  logic [127:0]      core_cipherText;
  logic              core_cipherReady;
`ifdef IBR128_ARB_TIMEOUT_EN
  logic              rsp_err;
`endif

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  logic model_on = 1'b1;
  logic spur = 1'b0;

  ibr128_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(16)) dut (
    .Clk(Clk), .RstN(RstN), .req_valid(req_valid), .req_ready(req_ready),
    .req_encrypt(req_encrypt), .req_sa(req_sa), .req_fb(req_fb),
    .req_som(req_som), .req_text(req_text), .req_iv(req_iv),
    .req_key0(req_key0), .req_key1(req_key1), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_text(rsp_text), .core_Enable(core_Enable),
    .core_SA(core_SA), .core_Encrypt(core_Encrypt), .core_FB(core_FB),
    .core_SOM(core_SOM), .core_plainText(core_plainText), .core_IV(core_IV),
    .core_key0(core_key0), .core_key1(core_key1),
    .core_cipherText(core_cipherText), .core_cipherReady(core_cipherReady)
`ifdef IBR128_ARB_TIMEOUT_EN
    , .rsp_err(rsp_err)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Core model: counts Enable-high cycles, readies on the 11th.
  always @(posedge Clk) begin
    if (!core_Enable) en_cnt <= 0;
    else en_cnt <= en_cnt + 1;
  end
  assign core_cipherText  = ~core_plainText;
  assign core_cipherReady = spur | (model_on & core_Enable & (en_cnt == 10));

  typedef struct {
    logic [1:0]   valid;
    logic [127:0] t0;
    logic [127:0] t1;
    logic [1:0]   exp;
    int           bp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, 128'(req_ready), 128'd0);
    check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'd0);
    check({tag, "_rsp_text"}, rsp_text, 128'd0);
    check({tag, "_enable"}, 128'(core_Enable), 128'd0);
    check({tag, "_plaintext"}, core_plainText, 128'd0);
    check({tag, "_som"}, 128'(core_SOM), 128'd0);
    check({tag, "_key0"}, 128'(core_key0), 128'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int waited;
    int oi;
    logic [127:0] exp_t;
    logic [127:0] held;
    req_valid   = v.valid;
    req_text[0] = v.t0;
    req_text[1] = v.t1;
    #1;
    waited = 0;
    while (req_ready == 2'b00 && waited < 30) begin
      tick();
      waited++;
    end
    check("grant_wait", 128'(waited), 128'd0);
    check("grant", 128'(req_ready), 128'(v.exp));
    oi = v.exp[1] ? 1 : 0;
    exp_t = v.exp[1] ? v.t1 : v.t0;
    tick();
    check("load_enable", 128'(core_Enable), 128'd0);
    check("load_text", core_plainText, exp_t);
    check("load_som", 128'(core_SOM), 128'(req_som[oi]));
    check("load_key0", 128'(core_key0), 128'(req_key0[oi]));
    check("load_req_ready", 128'(req_ready), 128'd0);
    tick();
    check("run_enable", 128'(core_Enable), 128'd1);
    waited = 0;
    while (rsp_valid == 2'b00 && waited < 40) begin
      tick();
      waited++;
    end
    check("rsp_latency", 128'(waited), 128'd11);
    check("rsp_valid", 128'(rsp_valid), 128'(v.exp));
    check("rsp_text", rsp_text, ~exp_t);
    check("resp_enable", 128'(core_Enable), 128'd0);
    held = rsp_text;
    rsp_ready = ~v.exp;
    for (int i = 0; i < v.bp; i++) begin
      tick();
      check("bp_rsp_valid", 128'(rsp_valid), 128'(v.exp));
      check("bp_rsp_text", rsp_text, held);
      check("bp_req_ready", 128'(req_ready), 128'd0);
      check("bp_enable", 128'(core_Enable), 128'd0);
    end
    rsp_ready = 2'b11;
    tick();
    rsp_ready = 2'b00;
    spur = 1'b1;
    #1;
    for (int g = 0; g < GAP; g++) begin
      check("gap_rsp_valid", 128'(rsp_valid), 128'd0);
      check("gap_enable", 128'(core_Enable), 128'd0);
      check("gap_req_ready", 128'(req_ready), 128'd0);
      tick();
    end
    spur = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0] = '{2'b01, 128'h1234_56ab_cd13_2536_1234_56ab_cd13_2536, 128'h0, 2'b01, 0};
    vecs[1] = '{2'b10, 128'h0, 128'hfeed_beef_0000_1111_2222_3333_4444_5555, 2'b10, 0};
    vecs[2] = '{2'b11, 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef,
                128'ha5a5_a5a5_5a5a_5a5a_a5a5_a5a5_5a5a_5a5a, 2'b01, 0};
    vecs[3] = '{2'b11, 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef,
                128'ha5a5_a5a5_5a5a_5a5a_a5a5_a5a5_5a5a_5a5a, 2'b10, 1};
    vecs[4] = '{2'b11, 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000,
                128'h0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f, 2'b01, 0};
    vecs[5] = '{2'b11, 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000,
                128'h0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f, 2'b10, 2};
    vecs[6] = '{2'b10, 128'h0, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 2'b10, 0};
    vecs[7] = '{2'b11, 128'hdead_0000_beef_0000_cafe_0000_f00d_0001,
                128'h1, 2'b01, 20};

    RstN        = 1'b0;
    req_valid   = 2'b00;
    rsp_ready   = 2'b00;
    req_encrypt = 2'b01;
    req_sa      = 2'b10;
    req_fb      = 2'b01;
    req_som[0]  = SOM_CBC;
    req_som[1]  = SOM_OFB;
    req_text    = '0;
    req_iv[0]   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    req_iv[1]   = 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000;
    req_key0[0] = 64'h0011_2233_4455_6677;
    req_key0[1] = 64'h8899_aabb_ccdd_eeff;
    req_key1[0] = 64'h0f1e_2d3c_4b5a_6978;
    req_key1[1] = 64'h8796_a5b4_c3d2_e1f0;

    tick();
    tick();
    check_idle_outputs("reset");
    RstN = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Spurious core ready while idle must not start anything.
    req_valid = 2'b00;
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("spur_idle_rsp_valid", 128'(rsp_valid), 128'd0);
      check("spur_idle_enable", 128'(core_Enable), 128'd0);
    end
    spur = 1'b0;

    // Reset in the middle of RUN discards the transaction.
    req_valid = 2'b01;
    req_text[0] = 128'h7777_7777_7777_7777_7777_7777_7777_7777;
    #1;
    check("mid_grant", 128'(req_ready), 128'd1);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    tick();
    check("mid_run_enable", 128'(core_Enable), 128'd1);
    RstN = 1'b0;
    tick();
    RstN = 1'b1;
    check_idle_outputs("mid_reset");
    run_vec('{2'b11, 128'h3333_0000_3333_0000_3333_0000_3333_0001,
              128'h4444_0000_4444_0000_4444_0000_4444_0002, 2'b01, 0});

`ifdef IBR128_ARB_TIMEOUT_EN
    begin
      int n;
      model_on = 1'b0;
      req_valid = 2'b01;
      #1;
      check("to_grant", 128'(req_ready), 128'd1);
      tick();
      req_valid = 2'b00;
      tick();
      n = 0;
      while (core_Enable && n < 40) begin
        tick();
        n++;
      end
      check("to_run_cycles", 128'(n), 128'd16);
      check("to_rsp_valid", 128'(rsp_valid), 128'd1);
      check("to_rsp_err", 128'(rsp_err), 128'd1);
      check("to_rsp_text", rsp_text, 128'd0);
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      check("to_err_clear", 128'(rsp_err), 128'd0);
      check("to_valid_clear", 128'(rsp_valid), 128'd0);
      model_on = 1'b1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
